// File: rtl/pic_port_pkg.sv
// Shared types and constants for the PIC16C55 parallel-port responder.
// Pin indices describe the portA mapping used by the board wrapper.
package pic_port_pkg;

  localparam int BYTE_W   = 8;

  localparam int PA_STB   = 0;
  localparam int PA_RW    = 1;
  localparam int PA_ACK   = 2;
  localparam int PA_SPARE = 3;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_WAIT,
    RD_SETUP,
    ACK
  } portState_t;

endpackage

// File: rtl/pic_port_fifo.sv
// Synchronous FIFO with an occupancy count; the head entry is always visible.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module pic_port_fifo
  import pic_port_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = BYTE_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       pushData,
  input  logic                   pop,
  output logic [WIDTH-1:0]       headData,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= pushData;
  end

  assign headData = mem[rdPtr];
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/pic_port_responder.sv
// Far-end responder for the PIC16C55 STB/RW/ACK byte handshake on portA/portB.
// Bytes written by the PIC land in the RX FIFO; reads are served from the TX FIFO.
module pic_port_responder
  import pic_port_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int SETUP_CYC   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stb_i,
  input  logic                   rw_i,
  output logic                   ack_o,
  input  logic [BYTE_W-1:0]      data_i,
  output logic [BYTE_W-1:0]      data_o,
  output logic                   data_oe,
  output logic [BYTE_W-1:0]      rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  input  logic [BYTE_W-1:0]      tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [$clog2(DEPTH):0] rx_count,
  output logic [$clog2(DEPTH):0] tx_count,
  output logic                   abort_pulse
);

  localparam int CNT_W = $clog2(SETUP_CYC + 1);

  logic [SYNC_STAGES-1:0]             stbSync;
  logic [SYNC_STAGES-1:0]             rwSync;
  logic [SYNC_STAGES-1:0][BYTE_W-1:0] dataSync;
  logic                               stbS, rwS, stbD, strobeRise;
  logic [BYTE_W-1:0]                  dataS;

  portState_t        state, stateNext;
  logic [CNT_W-1:0]  setupCnt, cntNext;
  logic              oeReg, oeNext;
  logic [BYTE_W-1:0] dataOReg, dOutNext;
  logic              dirRd, dirNext;
  logic              rxPush, txPop, abortNow;

  logic              rxFull, rxEmpty, txFull, txEmpty;
  logic [BYTE_W-1:0] txHead;

  // Input synchronizers for the PIC-driven pins
  always_ff @(posedge clk) begin
    if (rst) begin
      stbSync  <= '0;
      rwSync   <= '0;
      dataSync <= '0;
      stbD     <= 1'b0;
    end else begin
      stbSync  <= {stbSync[SYNC_STAGES-2:0], stb_i};
      rwSync   <= {rwSync[SYNC_STAGES-2:0], rw_i};
      dataSync <= {dataSync[SYNC_STAGES-2:0], data_i};
      stbD     <= stbS;
    end
  end

  assign stbS       = stbSync[SYNC_STAGES-1];
  assign rwS        = rwSync[SYNC_STAGES-1];
  assign dataS      = dataSync[SYNC_STAGES-1];
  assign strobeRise = stbS & ~stbD;

  // Handshake FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      setupCnt <= '0;
      oeReg    <= 1'b0;
      dataOReg <= '0;
      dirRd    <= 1'b0;
    end else begin
      state    <= stateNext;
      setupCnt <= cntNext;
      oeReg    <= oeNext;
      dataOReg <= dOutNext;
      dirRd    <= dirNext;
    end
  end

  // A low strobe before ACK is an abort and always beats a pending push.
  always_comb begin
    stateNext = state;
    cntNext   = setupCnt;
    oeNext    = oeReg;
    dOutNext  = dataOReg;
    dirNext   = dirRd;
    rxPush    = 1'b0;
    txPop     = 1'b0;
    abortNow  = 1'b0;
    case (state)
      IDLE: begin
        oeNext = 1'b0;
        if (strobeRise) begin
          dirNext   = rwS;
          stateNext = rwS ? RD_WAIT : WR;
        end
      end
      WR: begin
        if (!stbS) begin
          abortNow  = 1'b1;
          stateNext = IDLE;
        end else if (!rxFull) begin
          rxPush    = 1'b1;
          stateNext = ACK;
        end
      end
      RD_WAIT: begin
        if (!stbS) begin
          abortNow  = 1'b1;
          stateNext = IDLE;
        end else if (!txEmpty) begin
          oeNext    = 1'b1;
          dOutNext  = txHead;
          cntNext   = CNT_W'(SETUP_CYC);
          stateNext = RD_SETUP;
        end
      end
      RD_SETUP: begin
        if (!stbS) begin
          abortNow  = 1'b1;
          oeNext    = 1'b0;
          stateNext = IDLE;
        end else if (setupCnt == CNT_W'(1)) begin
          stateNext = ACK;
        end else begin
          cntNext = setupCnt - CNT_W'(1);
        end
      end
      ACK: begin
        if (!stbS) begin
          txPop     = dirRd;
          oeNext    = 1'b0;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // ACK and the bus drive drop in the very cycle the strobe is seen low.
  assign ack_o       = (state == ACK) & stbS;
  assign data_oe     = oeReg & stbS;
  assign data_o      = dataOReg;
  assign abort_pulse = abortNow;

  pic_port_fifo #(.DEPTH(DEPTH), .WIDTH(BYTE_W)) rxFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (rxPush),
    .pushData (dataS),
    .pop      (rx_valid & rx_ready),
    .headData (rx_data),
    .full     (rxFull),
    .empty    (rxEmpty),
    .count    (rx_count)
  );

  pic_port_fifo #(.DEPTH(DEPTH), .WIDTH(BYTE_W)) txFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (tx_valid & tx_ready),
    .pushData (tx_data),
    .pop      (txPop),
    .headData (txHead),
    .full     (txFull),
    .empty    (txEmpty),
    .count    (tx_count)
  );

  assign rx_valid = ~rxEmpty;
  assign tx_ready = ~txFull;

endmodule

// File: tb/tb_pic_port_responder.sv
// Bench for pic_port_responder: directed handshake scenarios plus randomized PIC/host
// traffic, checked every cycle against a transaction-level model with queue FIFOs.
module tb_pic_port_responder;

  localparam int DEPTH = 8;
  localparam int SYNC  = 2;
  localparam int SETUP = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stb_i = 1'b0;
  logic          rw_i = 1'b0;
  logic [7:0]    data_i = 8'h00;
  logic          rx_ready = 1'b0;
  logic [7:0]    tx_data = 8'h00;
  logic          tx_valid = 1'b0;
  logic          ack_o, data_oe, rx_valid, tx_ready, abort_pulse;
  logic [7:0]    data_o, rx_data;
  logic [CW-1:0] rx_count, tx_count;

  int vectors = 0;
  int miscompares = 0;
  bit hostRandom = 0;

  always #5 clk = ~clk;

  pic_port_responder #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC), .SETUP_CYC(SETUP)) dut (
    .clk         (clk),
    .rst         (rst),
    .stb_i       (stb_i),
    .rw_i        (rw_i),
    .ack_o       (ack_o),
    .data_i      (data_i),
    .data_o      (data_o),
    .data_oe     (data_oe),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_count    (rx_count),
    .tx_count    (tx_count),
    .abort_pulse (abort_pulse)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: delayed pin copies, a pending-transfer record, queue FIFOs
  bit         mStb [SYNC];
  bit         mRw  [SYNC];
  logic [7:0] mDat [SYNC];
  bit         mStbPrev;
  int         mTxn;      // 0 none, 1 PIC write, 2 PIC read
  bit         mAcked;
  int         mSetup;    // -1 until read data is on the bus
  bit         mOe;
  logic [7:0] mDout;
  logic [7:0] rxQ[$];
  logic [7:0] txQ[$];

  task automatic modelReset();
    for (int i = 0; i < SYNC; i++) begin
      mStb[i] = 0; mRw[i] = 0; mDat[i] = 8'h00;
    end
    mStbPrev = 0; mTxn = 0; mAcked = 0; mSetup = -1; mOe = 0; mDout = 8'h00;
    rxQ.delete(); txQ.delete();
  endtask

  task automatic compareCycle();
    bit s;
    s = mStb[SYNC-1];
    chk("cyc ack_o", 32'(ack_o), 32'(mAcked && s));
    chk("cyc data_oe", 32'(data_oe), 32'(mOe && s));
    chk("cyc data_o", 32'(data_o), 32'(mDout));
    chk("cyc abort_pulse", 32'(abort_pulse), 32'(mTxn != 0 && !mAcked && !s));
    chk("cyc rx_valid", 32'(rx_valid), 32'(rxQ.size() > 0));
    chk("cyc rx_count", 32'(rx_count), 32'(rxQ.size()));
    chk("cyc tx_ready", 32'(tx_ready), 32'(txQ.size() < DEPTH));
    chk("cyc tx_count", 32'(tx_count), 32'(txQ.size()));
    if (rxQ.size() > 0) chk("cyc rx_data", 32'(rx_data), 32'(rxQ[0]));
  endtask

  task automatic modelStep();
    bit s, r, hostPop, hostPush, picPush, picPop;
    logic [7:0] d;
    s = mStb[SYNC-1]; r = mRw[SYNC-1]; d = mDat[SYNC-1];
    if (rst) begin
      modelReset();
      return;
    end
    hostPop  = rx_ready && rxQ.size() > 0;
    hostPush = tx_valid && txQ.size() < DEPTH;
    picPush = 0; picPop = 0;
    if (mTxn == 0) begin
      if (s && !mStbPrev) begin
        mTxn = r ? 2 : 1; mAcked = 0; mSetup = -1;
      end
    end else if (!mAcked) begin
      if (!s) begin
        mTxn = 0; mOe = 0;
      end else if (mTxn == 1) begin
        if (rxQ.size() < DEPTH) begin picPush = 1; mAcked = 1; end
      end else if (mSetup < 0) begin
        if (txQ.size() > 0) begin mOe = 1; mDout = txQ[0]; mSetup = SETUP; end
      end else begin
        mSetup--;
        if (mSetup == 0) mAcked = 1;
      end
    end else if (!s) begin
      picPop = (mTxn == 2); mOe = 0; mTxn = 0; mAcked = 0;
    end
    if (hostPop)  void'(rxQ.pop_front());
    if (picPush)  rxQ.push_back(d);
    if (picPop)   void'(txQ.pop_front());
    if (hostPush) txQ.push_back(tx_data);
    mStbPrev = s;
    for (int i = SYNC - 1; i > 0; i--) begin
      mStb[i] = mStb[i-1]; mRw[i] = mRw[i-1]; mDat[i] = mDat[i-1];
    end
    mStb[0] = stb_i; mRw[0] = rw_i; mDat[0] = data_i;
  endtask

  initial begin
    modelReset();
    forever begin
      @(negedge clk);
      compareCycle();
      modelStep();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (hostRandom) begin
      tx_valid = ($urandom_range(0, 3) == 0);
      tx_data  = 8'($urandom);
      rx_ready = ($urandom_range(0, 2) == 0);
    end
  endtask

  task automatic picXfer(input bit rd, input logic [7:0] d, input int maxWait,
                         output bit got, output logic [7:0] q);
    rw_i = rd; data_i = d; stb_i = 1'b1; got = 0; q = 8'h00;
    for (int i = 0; i < maxWait && !got; i++) begin
      tick();
      if (hostRandom && i >= 2 && $urandom_range(0, 3) == 0) rw_i = ~rw_i;
      if (ack_o === 1'b1) begin got = 1; q = data_o; end
    end
    stb_i = 1'b0;
    repeat (SYNC + 2) tick();
    chk("ack released", 32'(ack_o), 32'd0);
  endtask

  bit         got;
  logic [7:0] q;

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    chk("reset ack_o", 32'(ack_o), 32'd0);
    chk("reset data_oe", 32'(data_oe), 32'd0);
    chk("reset tx_ready", 32'(tx_ready), 32'd1);
    repeat (2) tick();

    // PIC write 0xA5: ACK four cycles after the strobe
    rw_i = 1'b0; data_i = 8'hA5; stb_i = 1'b1;
    repeat (3) tick();
    chk("wr ack early", 32'(ack_o), 32'd0);
    tick();
    chk("wr ack rise", 32'(ack_o), 32'd1);
    chk("wr rx_data", 32'(rx_data), 32'hA5);
    chk("wr rx_valid", 32'(rx_valid), 32'd1);
    chk("wr rx_count", 32'(rx_count), 32'd1);
    stb_i = 1'b0;
    repeat (2) tick();
    chk("wr ack fall", 32'(ack_o), 32'd0);
    repeat (2) tick();
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    chk("wr popped", 32'(rx_count), 32'd0);

    // Read with preloaded TX
    tx_valid = 1'b1; tx_data = 8'h3C; tick();
    tx_data = 8'h7E; tick(); tx_valid = 1'b0;
    chk("rd preload count", 32'(tx_count), 32'd2);
    rw_i = 1'b1; stb_i = 1'b1;
    repeat (4) tick();
    chk("rd oe rise", 32'(data_oe), 32'd1);
    chk("rd data_o", 32'(data_o), 32'h3C);
    chk("rd ack not yet", 32'(ack_o), 32'd0);
    repeat (2) tick();
    chk("rd ack rise", 32'(ack_o), 32'd1);
    chk("rd data held", 32'(data_o), 32'h3C);
    stb_i = 1'b0;
    repeat (4) tick();
    chk("rd tx_count 1", 32'(tx_count), 32'd1);
    chk("rd oe off", 32'(data_oe), 32'd0);
    picXfer(1'b1, 8'h00, 40, got, q);
    chk("rd2 acked", 32'(got), 32'd1);
    chk("rd2 data", 32'(q), 32'h7E);
    chk("rd2 tx_count 0", 32'(tx_count), 32'd0);

    // RX full back-pressure
    for (int i = 0; i < DEPTH; i++) begin
      picXfer(1'b0, 8'(i), 40, got, q);
      chk("fill acked", 32'(got), 32'd1);
    end
    chk("fill count", 32'(rx_count), 32'(DEPTH));
    rw_i = 1'b0; data_i = 8'd8; stb_i = 1'b1;
    repeat (12) tick();
    chk("full no ack", 32'(ack_o), 32'd0);
    chk("full head", 32'(rx_data), 32'd0);
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    got = 0;
    for (int i = 0; i < 6 && !got; i++) begin
      tick();
      if (ack_o === 1'b1) got = 1;
    end
    chk("full ack after pop", 32'(got), 32'd1);
    stb_i = 1'b0;
    repeat (4) tick();
    for (int i = 1; i <= DEPTH; i++) begin
      chk("full order", 32'(rx_data), 32'(i));
      rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    end
    chk("full drained", 32'(rx_count), 32'd0);

    // Read on empty TX, then fill
    rw_i = 1'b1; stb_i = 1'b1;
    repeat (12) tick();
    chk("empty rd oe", 32'(data_oe), 32'd0);
    tx_valid = 1'b1; tx_data = 8'h11; tick(); tx_valid = 1'b0;
    chk("empty rd oe at push", 32'(data_oe), 32'd0);
    tick();
    chk("empty rd oe rise", 32'(data_oe), 32'd1);
    chk("empty rd data", 32'(data_o), 32'h11);
    tick();
    chk("empty rd ack wait", 32'(ack_o), 32'd0);
    tick();
    chk("empty rd ack", 32'(ack_o), 32'd1);
    stb_i = 1'b0;
    repeat (4) tick();
    chk("empty rd tx_count", 32'(tx_count), 32'd0);

    // Abort while stalled on full RX
    for (int i = 0; i < DEPTH; i++) picXfer(1'b0, 8'(8'h40 + i), 40, got, q);
    rw_i = 1'b0; data_i = 8'hEE; stb_i = 1'b1;
    repeat (6) tick();
    stb_i = 1'b0;
    tick();
    chk("abort early", 32'(abort_pulse), 32'd0);
    tick();
    chk("abort pulse", 32'(abort_pulse), 32'd1);
    tick();
    chk("abort one cycle", 32'(abort_pulse), 32'd0);
    chk("abort rx_count", 32'(rx_count), 32'(DEPTH));
    repeat (2) tick();

    // Reset during a read ACK
    tx_valid = 1'b1; tx_data = 8'h55; tick(); tx_valid = 1'b0;
    rw_i = 1'b1; stb_i = 1'b1; got = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      tick();
      if (ack_o === 1'b1) got = 1;
    end
    chk("rst ack reached", 32'(got), 32'd1);
    chk("rst oe before", 32'(data_oe), 32'd1);
    rst = 1'b1; stb_i = 1'b0;
    tick();
    chk("rst ack_o", 32'(ack_o), 32'd0);
    chk("rst data_oe", 32'(data_oe), 32'd0);
    chk("rst rx_count", 32'(rx_count), 32'd0);
    chk("rst tx_count", 32'(tx_count), 32'd0);
    rst = 1'b0;
    repeat (3) tick();

    // Randomized traffic against the model
    hostRandom = 1;
    for (int n = 0; n < 120; n++) begin
      picXfer(1'($urandom_range(0, 1)), 8'($urandom),
              ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 4)) : 40, got, q);
      repeat ($urandom_range(0, 3)) tick();
    end
    hostRandom = 0; tx_valid = 1'b0; rx_ready = 1'b0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
